vball_gfx_rom: RTL and testbench



---
 rtl/vball_gfx_pkg.sv | 13 +
 rtl/vball_gfx_wordbuf.sv | 39 +++
 rtl/vball_gfx_rom.sv | 85 ++++++++
 tb/tb_vball_gfx_rom.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vball_gfx_pkg.sv
// vball_gfx_pkg: shared types, widths and defaults for the VBall gfx-ROM responder.
package vball_gfx_pkg;
    localparam int GFX_AW = 19;
    localparam int MEM_AW = 18;
    localparam int MEM_DW = 16;
    localparam int DEADLINE_DEFAULT = 8;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    function automatic logic [7:0] sel_byte(input logic [MEM_DW-1:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction
endpackage

// File: rtl/vball_gfx_wordbuf.sv
// vball_gfx_wordbuf: single-word tag buffer with hit compare, byte select and flush priority.
module vball_gfx_wordbuf
    import vball_gfx_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              flush,
    input  logic              fill,
    input  logic [MEM_AW-1:0] fill_tag,
    input  logic [MEM_DW-1:0] fill_word,
    input  logic [MEM_AW-1:0] lookup_tag,
    input  logic              byte_hi,
    output logic              hit,
    output logic [7:0]        data
);
    logic [MEM_AW-1:0] tag;
    logic [MEM_DW-1:0] word;
    logic              tvalid;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tag    <= '0;
            word   <= '0;
            tvalid <= 1'b0;
        end else begin
            if (fill) begin
                tag  <= fill_tag;
                word <= fill_word;
            end
            tvalid <= !flush && (fill || tvalid);
        end
    end

    // On a fill the byte comes straight from the incoming word so it can be registered this cycle.
    always_comb begin
        hit  = tvalid && (tag == lookup_tag);
        data = sel_byte(fill ? fill_word : word, byte_hi);
    end
endmodule

// File: rtl/vball_gfx_rom.sv
// vball_gfx_rom: gfx-ROM fetch responder; serves bytes from a tag buffer or fetches 16-bit words from SDRAM.
module vball_gfx_rom
    import vball_gfx_pkg::*;
#(
    parameter int DEADLINE = DEADLINE_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              gfx_read,
    input  logic [GFX_AW-1:0] gfx_addr,
    output logic [7:0]        gfx_data,
    output logic              gfx_valid,
    input  logic              flush,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [MEM_DW-1:0] mem_data,
    output logic              late
);
    state_t     state, state_n;
    logic       prev, start, hit, issue, fill, load, valid_n, waiting;
    logic [7:0] byte_out;
    logic [3:0] cnt;

    vball_gfx_wordbuf u_buf (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .flush     (flush),
        .fill      (fill),
        .fill_tag  (mem_addr),
        .fill_word (mem_data),
        .lookup_tag(gfx_addr[GFX_AW-1:1]),
        .byte_hi   (gfx_addr[0]),
        .hit       (hit),
        .data      (byte_out)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Rising edges outside IDLE are ignored; a dropped read in WAIT still completes the fill.
    always_comb begin
        state_n = state;
        if (state == IDLE && start)     state_n = hit ? HOLD : WAIT;
        if (state == WAIT && mem_ack)   state_n = gfx_read ? HOLD : IDLE;
        if (state == HOLD && !gfx_read) state_n = IDLE;
    end

    always_comb begin
        start   = gfx_read && !prev;
        issue   = state == IDLE && start && !hit;
        fill    = state == WAIT && mem_ack;
        waiting = state == WAIT && !mem_ack;
        load    = (state == IDLE && start && hit) || (fill && gfx_read);
        valid_n = load || (state == HOLD && gfx_read);
    end

    // cnt holds the cycle number since request start while waiting, saturating at DEADLINE.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            prev      <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            gfx_data  <= '0;
            gfx_valid <= 1'b0;
            cnt       <= '0;
            late      <= 1'b0;
        end else begin
            prev      <= gfx_read;
            gfx_valid <= valid_n;
            if (load) gfx_data <= byte_out;
            if (issue) begin
                mem_req  <= 1'b1;
                mem_addr <= gfx_addr[GFX_AW-1:1];
                cnt      <= 4'd1;
            end else if (waiting && cnt != 4'(DEADLINE)) begin
                cnt <= cnt + 4'd1;
            end
            if (fill) mem_req <= 1'b0;
            if (waiting && cnt + 4'd1 == 4'(DEADLINE)) late <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vball_gfx_rom.sv
// tb_vball_gfx_rom: directed checks of hit/miss timing, deadline, flush race, abort and reset in WAIT.
module tb_vball_gfx_rom;
    logic        clk_sys = 1'b0;
    logic        reset, gfx_read, flush, mem_ack;
    logic [18:0] gfx_addr;
    logic [15:0] mem_data;
    logic [7:0]  gfx_data;
    logic        gfx_valid, mem_req, late;
    logic [17:0] mem_addr;
    int          n_cmp = 0;
    int          n_bad = 0;

    vball_gfx_rom #(.DEADLINE(8)) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .gfx_read (gfx_read),
        .gfx_addr (gfx_addr),
        .gfx_data (gfx_data),
        .gfx_valid(gfx_valid),
        .flush    (flush),
        .mem_addr (mem_addr),
        .mem_req  (mem_req),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .late     (late)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1; gfx_read = 0; gfx_addr = 0; flush = 0; mem_ack = 0; mem_data = 0;
        ticks(3);
        reset = 0;
        ticks(1);
        check("rst_valid", gfx_valid, 0);
        check("rst_data", gfx_data, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_late", late, 0);

        // cold miss, ack at cycle 4
        gfx_addr = 19'h12345; gfx_read = 1;
        ticks(1);
        check("miss_req_c1", mem_req, 1);
        check("miss_addr_c1", mem_addr, 18'h091A2);
        check("miss_valid_c1", gfx_valid, 0);
        ticks(3);
        check("miss_req_c4", mem_req, 1);
        mem_ack = 1; mem_data = 16'hBEEF;
        ticks(1);
        mem_ack = 0;
        check("miss_valid_c5", gfx_valid, 1);
        check("miss_data_c5", gfx_data, 8'hBE);
        check("miss_req_c5", mem_req, 0);
        check("miss_late", late, 0);
        gfx_read = 0;
        ticks(1);
        check("miss_valid_drop", gfx_valid, 0);
        ticks(1);

        // hit on the other byte of the same word
        gfx_addr = 19'h12344; gfx_read = 1;
        ticks(1);
        check("hit_valid_c1", gfx_valid, 1);
        check("hit_data_c1", gfx_data, 8'hEF);
        check("hit_req_c1", mem_req, 0);
        gfx_read = 0;
        ticks(2);

        // deadline miss, ack at cycle 10
        gfx_addr = 19'h00100; gfx_read = 1;
        ticks(7);
        check("dl_late_c7", late, 0);
        ticks(1);
        check("dl_late_c8", late, 1);
        check("dl_req_c8", mem_req, 1);
        ticks(2);
        mem_ack = 1; mem_data = 16'h1234;
        ticks(1);
        mem_ack = 0;
        check("dl_valid_c11", gfx_valid, 1);
        check("dl_data_c11", gfx_data, 8'h34);
        gfx_read = 0;
        ticks(2);
        check("dl_late_sticky", late, 1);

        // flush coincident with ack
        gfx_addr = 19'h00201; gfx_read = 1;
        ticks(3);
        mem_ack = 1; flush = 1; mem_data = 16'hA55A;
        ticks(1);
        mem_ack = 0; flush = 0;
        check("fl_valid", gfx_valid, 1);
        check("fl_data", gfx_data, 8'hA5);
        gfx_read = 0;
        ticks(2);
        gfx_addr = 19'h00200; gfx_read = 1;
        ticks(1);
        check("fl_refetch_req", mem_req, 1);
        check("fl_refetch_valid", gfx_valid, 0);
        ticks(1);
        mem_ack = 1;
        ticks(1);
        mem_ack = 0;
        check("fl_refetch_data", gfx_data, 8'h5A);
        gfx_read = 0;
        ticks(2);
        check("fl_late_sticky", late, 1);
        reset = 1;
        ticks(1);
        reset = 0;
        ticks(1);
        check("late_cleared", late, 0);

        // abort at cycle 3, ack at cycle 5, top address
        gfx_addr = 19'h7FFFF; gfx_read = 1;
        ticks(1);
        check("ab_req_c1", mem_req, 1);
        check("ab_addr_c1", mem_addr, 18'h3FFFF);
        ticks(2);
        gfx_read = 0;
        ticks(2);
        mem_ack = 1; mem_data = 16'hC3D2;
        ticks(1);
        mem_ack = 0;
        check("ab_valid_c6", gfx_valid, 0);
        check("ab_req_c6", mem_req, 0);
        ticks(1);
        gfx_addr = 19'h7FFFE; gfx_read = 1;
        ticks(1);
        check("ab_hit_valid", gfx_valid, 1);
        check("ab_hit_data", gfx_data, 8'hD2);
        check("ab_hit_req", mem_req, 0);
        gfx_read = 0;
        ticks(2);

        // reset at cycle 2 of a miss, stray ack at cycle 4
        gfx_addr = 19'h00010; gfx_read = 1;
        ticks(2);
        reset = 1; gfx_read = 0;
        ticks(1);
        reset = 0;
        check("rw_req", mem_req, 0);
        check("rw_addr", mem_addr, 0);
        check("rw_valid", gfx_valid, 0);
        check("rw_data", gfx_data, 0);
        ticks(1);
        mem_ack = 1; mem_data = 16'h7777;
        ticks(1);
        mem_ack = 0;
        check("rw_ack_req", mem_req, 0);
        check("rw_ack_valid", gfx_valid, 0);
        check("rw_ack_data", gfx_data, 0);
        gfx_read = 1;
        ticks(1);
        check("rw_refetch_req", mem_req, 1);
        check("rw_refetch_addr", mem_addr, 18'h00008);
        mem_ack = 1; mem_data = 16'h0F0E;
        ticks(1);
        mem_ack = 0;
        check("rw_refetch_valid", gfx_valid, 1);
        check("rw_refetch_data", gfx_data, 8'h0E);
        gfx_read = 0;
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
